// File: rtl/if_id_stage.sv
// IF/ID pipeline register: one-cycle capture of fetch into the decode slot, with stall hold,
// jump flush, branch-shadow bubbles and interrupt acceptance (bubble + epc capture).
module if_id_stage #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                HOLD_W     = 3,
    parameter logic [HOLD_W-1:0] HOLD_IF    = 3'd2,
    parameter logic [HOLD_W-1:0] HOLD_PPL   = 3'd3,
    parameter logic [DATA_W-1:0] NOP        = 32'h0000_0000,
    parameter int                SHADOW_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_data,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              hold_pc,
    input  logic [HOLD_W-1:0] hold_flag,
    input  logic              jump_flag,
    input  logic              int_req,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid,
    output logic              int_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              busy
);

    localparam int CNT_W = $clog2(SHADOW_CYC + 1);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  inst_q, inst_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               ack_q, ack_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic               stall;

    assign stall = (hold_flag == HOLD_IF) || (hold_flag == HOLD_PPL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ack_d   = 1'b0;
        epc_d   = epc_q;

        unique case (state_q)
            RUN: begin
                if (jump_flag) begin
                    inst_d  = NOP;
                    pc_d    = inst_addr;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // hold everything; a pending interrupt waits for an unstalled edge
                end else if (int_req) begin
                    // fetched word is dropped so execution resumes at epc, including a branch
                    inst_d  = NOP;
                    pc_d    = inst_addr;
                    valid_d = 1'b0;
                    epc_d   = inst_addr;
                    ack_d   = 1'b1;
                end else if (inst_data == NOP) begin
                    inst_d  = NOP;
                    pc_d    = inst_addr;
                    valid_d = 1'b0;
                end else begin
                    inst_d  = inst_data;
                    pc_d    = inst_addr;
                    valid_d = 1'b1;
                    if (hold_pc) begin
                        cnt_d   = CNT_W'(SHADOW_CYC);
                        state_d = SHADOW;
                    end
                end
            end
            SHADOW: begin
                if (jump_flag) begin
                    inst_d  = NOP;
                    pc_d    = inst_addr;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (!stall) begin
                    inst_d  = NOP;
                    pc_d    = inst_addr;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            inst_q  <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            epc_q   <= epc_d;
        end
    end

    assign id_inst  = inst_q;
    assign id_pc    = pc_q;
    assign id_valid = valid_q;
    assign int_ack  = ack_q;
    assign epc      = epc_q;
    assign busy     = (state_q == SHADOW);

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: each driven cycle pushes its expected post-edge outputs,
// and a monitor pops and compares them just after the following rising edge.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
    logic        hold_pc;
    logic [2:0]  hold_flag;
    logic        jump_flag;
    logic        int_req;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        int_ack;
    logic [31:0] epc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        vld;
        logic        ack;
        logic [31:0] epc;
        logic        busy;
        int          idx;
    } exp_t;

    exp_t sb_q[$];
    int   step_no = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .inst_data (inst_data),
        .inst_addr (inst_addr),
        .hold_pc   (hold_pc),
        .hold_flag (hold_flag),
        .jump_flag (jump_flag),
        .int_req   (int_req),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_valid  (id_valid),
        .int_ack   (int_ack),
        .epc       (epc),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and record what the slot must hold after the edge.
    task automatic step(input logic r, input logic [31:0] d, input logic [31:0] a,
                        input logic hp, input logic [2:0] hf, input logic j, input logic iq,
                        input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_vld,
                        input logic e_ack, input logic [31:0] e_epc, input logic e_busy);
        exp_t e;
        @(negedge clk);
        rst = r; inst_data = d; inst_addr = a; hold_pc = hp;
        hold_flag = hf; jump_flag = j; int_req = iq;
        step_no++;
        e.inst = e_inst; e.pc = e_pc; e.vld = e_vld; e.ack = e_ack;
        e.epc = e_epc; e.busy = e_busy; e.idx = step_no;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("s%0d.id_inst", e.idx), id_inst, e.inst);
            chk($sformatf("s%0d.id_pc", e.idx), id_pc, e.pc);
            chk($sformatf("s%0d.id_valid", e.idx), {31'd0, id_valid}, {31'd0, e.vld});
            chk($sformatf("s%0d.int_ack", e.idx), {31'd0, int_ack}, {31'd0, e.ack});
            chk($sformatf("s%0d.epc", e.idx), epc, e.epc);
            chk($sformatf("s%0d.busy", e.idx), {31'd0, busy}, {31'd0, e.busy});
        end
    end

    initial begin
        rst = 1'b1; inst_data = '0; inst_addr = '0; hold_pc = 1'b0;
        hold_flag = 3'd0; jump_flag = 1'b0; int_req = 1'b0;

        // reset, then a two-word stream
        step(1, 32'h0, 0, 0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h123, 0, 0, 0, 0, 0,  32'h123, 0, 1, 0, 0, 0);
        step(0, 32'h456, 1, 0, 0, 0, 0,  32'h456, 1, 1, 0, 0, 0);

        // pipeline stall holds the slot, new word captured afterwards
        step(0, 32'h123, 4, 0, 0, 0, 0,  32'h123, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 32'h777, 5, 0, 3'd3, 0, 0,  32'h123, 4, 1, 0, 0, 0);
        step(0, 32'h777, 5, 0, 0, 0, 0,  32'h777, 5, 1, 0, 0, 0);
        step(0, 32'h0, 6, 0, 0, 0, 0,  32'h0, 6, 0, 0, 0, 0);
        // hold_pc with a NOP fetch does not open a shadow
        step(0, 32'h0, 7, 1, 0, 0, 0,  32'h0, 7, 0, 0, 0, 0);

        // branch fall-through: two bubbles then capture
        step(0, 32'hA01, 8, 1, 0, 0, 0,  32'hA01, 8, 1, 0, 0, 1);
        step(0, 32'h222, 9, 0, 0, 0, 0,  32'h0, 9, 0, 0, 0, 1);
        step(0, 32'h222, 9, 0, 0, 0, 0,  32'h0, 9, 0, 0, 0, 0);
        step(0, 32'h222, 9, 0, 0, 0, 0,  32'h222, 9, 1, 0, 0, 0);

        // branch taken while stalled: jump wins
        step(0, 32'hA01, 8, 1, 0, 0, 0,  32'hA01, 8, 1, 0, 0, 1);
        step(0, 32'h333, 20, 0, 3'd2, 1, 0,  32'h0, 20, 0, 0, 0, 0);
        step(0, 32'h333, 20, 0, 0, 0, 0,  32'h333, 20, 1, 0, 0, 0);

        // stall inside the shadow freezes the counter
        step(0, 32'hA01, 8, 1, 0, 0, 0,  32'hA01, 8, 1, 0, 0, 1);
        step(0, 32'h444, 9, 0, 3'd2, 0, 0,  32'hA01, 8, 1, 0, 0, 1);
        step(0, 32'h444, 9, 0, 0, 0, 0,  32'h0, 9, 0, 0, 0, 1);
        step(0, 32'h444, 9, 0, 0, 0, 0,  32'h0, 9, 0, 0, 0, 0);
        step(0, 32'h444, 9, 0, 0, 0, 0,  32'h444, 9, 1, 0, 0, 0);

        // interrupt acceptance, one-cycle ack
        step(0, 32'h555, 12, 0, 0, 0, 1,  32'h0, 12, 0, 1, 12, 0);
        step(0, 32'h556, 12, 0, 0, 0, 0,  32'h556, 12, 1, 0, 12, 0);
        // stalled: interrupt not accepted
        step(0, 32'h557, 13, 0, 3'd3, 0, 1,  32'h556, 12, 1, 0, 12, 0);
        // branch arriving with int_req: interrupt wins, no shadow
        step(0, 32'hA02, 16, 1, 0, 0, 1,  32'h0, 16, 0, 1, 16, 0);

        // int_req held through a shadow is deferred until RUN
        step(0, 32'hA03, 17, 1, 0, 0, 0,  32'hA03, 17, 1, 0, 16, 1);
        step(0, 32'h600, 18, 0, 0, 0, 1,  32'h0, 18, 0, 0, 16, 1);
        step(0, 32'h600, 18, 0, 0, 0, 1,  32'h0, 18, 0, 0, 16, 0);
        step(0, 32'h600, 18, 0, 0, 0, 1,  32'h0, 18, 0, 1, 18, 0);
        step(0, 32'h600, 18, 0, 0, 0, 0,  32'h600, 18, 1, 0, 18, 0);

        // reset with the shadow counter at 1
        step(0, 32'hA04, 20, 1, 0, 0, 0,  32'hA04, 20, 1, 0, 18, 1);
        step(0, 32'h700, 21, 0, 0, 0, 0,  32'h0, 21, 0, 0, 18, 1);
        step(1, 32'h700, 21, 0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h700, 22, 0, 0, 0, 0,  32'h700, 22, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) chk("drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
